// File: rtl/riscv_mc_controller_pkg.sv
// Shared definitions for the multicycle RISC-V controller and its datapath:
// FSM state encoding, opcodes, ALU control codes and mux select codes.
package riscv_mc_controller_pkg;

   // FSM states, 4-bit encoding
   typedef enum logic [3:0] {
      ST_RST    = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_EXECR  = 4'd7,
      ST_EXECI  = 4'd8,
      ST_ALUWB  = 4'd9,
      ST_BEQ    = 4'd10,
      ST_JAL    = 4'd11,
      ST_TRAP   = 4'd12
   } state_t;

   // Opcodes of the supported instruction classes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Coarse ALU operation requested by the FSM
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // ALU control codes understood by the datapath ALU
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Result mux selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // SrcA / SrcB selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Immediate formats
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format implied by the opcode
   function automatic logic [1:0] imm_decode(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// ALU control decoder: maps the FSM's coarse ALU op plus funct fields to the
// 3-bit ALU control code, and flags funct3 values the core does not implement.
module riscv_alu_decoder
   import riscv_mc_controller_pkg::*;
(
   input  aluop_t     aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       opcode5_i,
   output logic [2:0] alu_ctrl_o,
   output logic       illegal_funct_o
);

   logic [2:0] funct_ctrl;

   // Decode funct3 (sub only for R-type with funct7b5), then select by aluop
   always_comb begin
      funct_ctrl      = ALU_ADD;
      illegal_funct_o = 1'b0;
      case (funct3_i)
         3'b000:  funct_ctrl = (opcode5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_ctrl = ALU_SLT;
         3'b110:  funct_ctrl = ALU_OR;
         3'b111:  funct_ctrl = ALU_AND;
         default: illegal_funct_o = 1'b1;
      endcase
      case (aluop_i)
         ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
         ALUOP_FUNCT: alu_ctrl_o = funct_ctrl;
         default:     alu_ctrl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing each instruction,
// driving datapath selects/enables, resolving beq with the zero flag, and
// keeping a sticky illegal-instruction flag and a retired-instruction count.
module riscv_mc_controller
   import riscv_mc_controller_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   output logic                 pc_write,
   output logic                 adr_src,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 reg_write,
   output logic [1:0]           result_src,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           imm_src,
   output logic [2:0]           alu_ctrl,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_t                 state_q, state_d;
   logic                   illegal_q, illegal_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   aluop_t                 aluop;
   logic                   pc_update, branch, retire, illegal_funct;

   riscv_alu_decoder u_alu_dec (
      .aluop_i         (aluop),
      .funct3_i        (funct3),
      .funct7b5_i      (funct7b5),
      .opcode5_i       (opcode[5]),
      .alu_ctrl_o      (alu_ctrl),
      .illegal_funct_o (illegal_funct)
   );

   // Next-state and Moore outputs; every output defaults to its idle value
   always_comb begin
      state_d    = state_q;
      pc_update  = 1'b0;
      branch     = 1'b0;
      retire     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      aluop      = ALUOP_ADD;
      imm_src    = imm_decode(opcode);
      case (state_q)
         ST_RST: begin
            imm_src = IMM_I;
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_update  = 1'b1;
            state_d    = ST_DECODE;
         end
         ST_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = ST_MEMADR;
               OP_RTYPE:  state_d = illegal_funct ? ST_TRAP : ST_EXECR;
               OP_ITYPE:  state_d = illegal_funct ? ST_TRAP : ST_EXECI;
               OP_BRANCH: state_d = (funct3 == 3'b000) ? ST_BEQ : ST_TRAP;
               OP_JAL:    state_d = ST_JAL;
               default:   state_d = ST_TRAP;
            endcase
         end
         ST_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = opcode[5] ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            adr_src = 1'b1;
            state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_MEMWR: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_EXECR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            aluop     = ALUOP_FUNCT;
            state_d   = ST_ALUWB;
         end
         ST_EXECI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNCT;
            state_d   = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_BEQ: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            aluop     = ALUOP_SUB;
            branch    = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
            retire    = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_TRAP: begin
            imm_src = IMM_I;
            state_d = ST_TRAP;
         end
         default: begin
            imm_src = IMM_I;
            state_d = ST_RST;
         end
      endcase
   end

   assign pc_write = pc_update | (branch & zero);

   // Sticky illegal flag and retired-instruction counter
   always_comb begin
      illegal_d = illegal_q | (state_d == ST_TRAP);
      instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;
   end

   // State registers; reset takes effect immediately so strobes drop at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RST;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: table of directed instructions,
// hand-written reset/trap sequences and random instructions, all checked
// cycle by cycle against a per-instruction control-word sequence model.
module tb_riscv_mc_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  opcode = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        funct7b5 = 1'b0;
   logic        zero = 1'b0;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_ctrl;
   logic [31:0] instret;

   riscv_mc_controller #(.INSTRET_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .funct7b5(funct7b5), .zero(zero), .pc_write(pc_write),
      .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   // Control word: {pc_write, adr_src, mem_write, ir_write, reg_write,
   //                result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl}
   logic [15:0] dut_cw;
   assign dut_cw = {pc_write, adr_src, mem_write, ir_write, reg_write,
                    result_src, alu_src_a, alu_src_b, imm_src, alu_ctrl};

   int          vectors = 0;
   int          miscompares = 0;
   int          instret_m = 0;
   logic [15:0] exp_q[$];
   bit          exp_trap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] cw(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic regw, input logic [1:0] res,
                                      input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] imm, input logic [2:0] alu);
      return {pcw, adr, memw, irw, regw, res, a, b, imm, alu};
   endfunction

   // ALU code for an arithmetic instruction, straight from the funct rules
   function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         default: return 3'b010;
      endcase
   endfunction

   // Build the expected per-cycle control words for one instruction
   function automatic void build(input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic z);
      logic [1:0] imm;
      bit arith_ok;
      imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
      arith_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
      exp_q.delete();
      exp_trap = 1'b0;
      exp_q.push_back(cw(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000));
      exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000));
      if (op == 7'b0000011) begin
         exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000));
         exp_q.push_back(cw(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000));
         exp_q.push_back(cw(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000));
      end else if (op == 7'b0100011) begin
         exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000));
         exp_q.push_back(cw(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000));
      end else if ((op == 7'b0110011 || op == 7'b0010011) && arith_ok) begin
         exp_q.push_back(cw(0, 0, 0, 0, 0, 2'b00, 2'b10, (op == 7'b0110011) ? 2'b00 : 2'b01,
                            imm, funct_alu(op, f3, f7)));
         exp_q.push_back(cw(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000));
      end else if (op == 7'b1100011 && f3 == 3'b000) begin
         exp_q.push_back(cw(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b001));
      end else if (op == 7'b1101111) begin
         exp_q.push_back(cw(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000));
      end else begin
         exp_trap = 1'b1;
      end
   endfunction

   // Run one instruction starting in FETCH (called at posedge+1 of FETCH)
   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, input int exp_lat, input int exp_alu);
      int  k;
      bit  done;
      opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
      build(op, f3, f7, z);
      #1;
      chk($sformatf("%s.instret", name), instret, instret_m);
      chk($sformatf("%s.illegal", name), {31'd0, illegal}, 32'd0);
      chk($sformatf("%s.cyc1", name), {16'd0, dut_cw}, {16'd0, exp_q[0]});
      if (exp_trap) begin
         @(posedge clk); #1;
         chk($sformatf("%s.cyc2", name), {16'd0, dut_cw}, {16'd0, exp_q[1]});
         for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.trap%0d", name, t), {16'd0, dut_cw}, 32'd0);
            chk($sformatf("%s.trap_illegal%0d", name, t), {31'd0, illegal}, 32'd1);
         end
      end else begin
         k = 1;
         done = 1'b0;
         while (!done) begin
            @(posedge clk); #1;
            if (ir_write === 1'b1 || k >= 10) begin
               done = 1'b1;
            end else begin
               if (k < exp_q.size())
                  chk($sformatf("%s.cyc%0d", name, k + 1), {16'd0, dut_cw}, {16'd0, exp_q[k]});
               if (k == 2 && exp_alu >= 0)
                  chk($sformatf("%s.alu", name), {29'd0, alu_ctrl}, exp_alu);
               k++;
            end
         end
         chk($sformatf("%s.cycles", name), k, exp_q.size());
         if (exp_lat >= 0)
            chk($sformatf("%s.latency", name), k, exp_lat);
         instret_m++;
      end
   endtask

   // Reset pulse; returns at posedge+1 of the first FETCH
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst.cw", {16'd0, dut_cw}, 32'd0);
      chk("rst.instret", instret, 32'd0);
      chk("rst.illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst.rst_cycle", {16'd0, dut_cw}, 32'd0);
      @(posedge clk); #1;
      instret_m = 0;
   endtask

   typedef struct {
      string      name;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      int         lat;
      int         alu;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [6:0] rop;
      int         kind;

      tbl.push_back('{"lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 5, 0});
      tbl.push_back('{"sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 4, 0});
      tbl.push_back('{"add",   7'b0110011, 3'b000, 1'b0, 1'b0, 4, 0});
      tbl.push_back('{"sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 4, 1});
      tbl.push_back('{"slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 4, 5});
      tbl.push_back('{"or",    7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3});
      tbl.push_back('{"and",   7'b0110011, 3'b111, 1'b0, 1'b0, 4, 2});
      tbl.push_back('{"addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, 0});
      tbl.push_back('{"slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 4, 5});
      tbl.push_back('{"ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 4, 3});
      tbl.push_back('{"andi",  7'b0010011, 3'b111, 1'b0, 1'b0, 4, 2});
      tbl.push_back('{"beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 1});
      tbl.push_back('{"beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 1});
      tbl.push_back('{"jal",   7'b1101111, 3'b000, 1'b0, 1'b0, 3, 0});
      tbl.push_back('{"lui",   7'b0110111, 3'b000, 1'b0, 1'b0, -1, -1});
      tbl.push_back('{"r_f1",  7'b0110011, 3'b001, 1'b0, 1'b0, -1, -1});
      tbl.push_back('{"i_f5",  7'b0010011, 3'b101, 1'b0, 1'b0, -1, -1});
      tbl.push_back('{"bne",   7'b1100011, 3'b001, 1'b0, 1'b1, -1, -1});

      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Directed table
      foreach (tbl[i]) begin
         run_instr(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].lat, tbl[i].alu);
         $display("vec %s op=%b f3=%b f7=%b z=%b instret=%0d", tbl[i].name, tbl[i].op,
                  tbl[i].f3, tbl[i].f7, tbl[i].z, instret);
         if (exp_trap) do_reset();
      end

      // Reset asserted in the middle of a store
      run_instr("jal_pre", 7'b1101111, 3'b000, 1'b0, 1'b0, 3, 0);
      opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      build(opcode, funct3, funct7b5, zero);
      #1;
      chk("midrst.instret_pre", instret, instret_m);
      for (int c = 1; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("midrst.cyc%0d", c + 1), {16'd0, dut_cw}, {16'd0, exp_q[c]});
      end
      chk("midrst.mem_write_on", {31'd0, mem_write}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst.mem_write_off", {31'd0, mem_write}, 32'd0);
      chk("midrst.instret", instret, 32'd0);
      $display("vec midrst mem_write=%b instret=%0d", mem_write, instret);
      do_reset();

      // Random instructions
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 6);
         case (kind)
            0: rop = 7'b0000011;
            1: rop = 7'b0100011;
            2: rop = 7'b0110011;
            3: rop = 7'b0010011;
            4: rop = 7'b1100011;
            5: rop = 7'b1101111;
            default: rop = 7'($urandom);
         endcase
         run_instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom), 1'($urandom), -1, -1);
         $display("vec rnd%0d op=%b f3=%b f7=%b z=%b trap=%0d instret=%0d", n, opcode, funct3,
                  funct7b5, zero, exp_trap, instret);
         if (exp_trap) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
